// File: rtl/pkg_tamagotchi.sv
// Shared definitions for the pet-game control path: arbiter state encoding,
// button index constants and the default post-accept lockout length.
package pkg_tamagotchi;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam int BTN_COMIDA  = 0;
    localparam int BTN_BRINCAR = 1;
    localparam int BTN_LIMPAR  = 2;

    localparam logic [15:0] COOLDOWN_DEF = 16'd50000;

endpackage

// File: rtl/arbitro_rr.sv
// Purely combinational round-robin picker.
// Ports:
//   req    - request vector, one bit per button
//   last   - index of the most recently granted button
//   gnt_id - first requesting index found searching upward from last+1 (mod N)
//   any    - at least one request is present
module arbitro_rr #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    int idx;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        gnt_id = '0;
        any    = |req;
        idx    = 0;
        // Walk from the farthest candidate to the nearest so the nearest
        // requester after 'last' is the one left standing.
        for (int k = N; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;   // last < N and k <= N, so one wrap suffices
            for (int j = 0; j < N; j++) begin
                if (j == idx && req[j]) gnt_id = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/arbitro_botoes.sv
// Shares one command channel to the game FSM between N debounced buttons.
// Presses are latched as pending requests, granted round-robin, offered with
// a valid/ready handshake and followed by a cooldown lockout.
// Ports:
//   clk, rst   - clock; asynchronous active-high reset
//   b_pulse    - one-cycle press pulses, one bit per button
//   cmd_ready  - consumer accepts cmd_id this cycle
//   cmd_valid  - command offered
//   cmd_id     - index of the granted button
//   pending    - latched, not-yet-accepted requests
//   busy       - arbiter is not idle (offering or in cooldown)
//   drop       - one-cycle pulse: press lost because that button was already pending
module arbitro_botoes
    import pkg_tamagotchi::*;
#(
    parameter int          N_BOTOES = 3,
    parameter int          ID_W     = 2,
    parameter logic [15:0] COOLDOWN = COOLDOWN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] b_pulse,
    input  logic                cmd_ready,
    output logic                cmd_valid,
    output logic [ID_W-1:0]     cmd_id,
    output logic [N_BOTOES-1:0] pending,
    output logic                busy,
    output logic [N_BOTOES-1:0] drop
);

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [15:0]     cnt;
    logic [ID_W-1:0] rr_id;
    logic            rr_any;
    logic            accept;

    assign accept = cmd_valid && cmd_ready;

    arbitro_rr #(
        .N    (N_BOTOES),
        .ID_W (ID_W)
    ) u_rr (
        .req    (pending),
        .last   (last_grant),
        .gnt_id (rr_id),
        .any    (rr_any)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            pending    <= '0;
            drop       <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
            last_grant <= ID_W'(N_BOTOES - 1);   // button 0 wins the first round
        end else begin
            // Request latch. A press landing on the accept edge of the same
            // button becomes a fresh request instead of being dropped.
            for (int i = 0; i < N_BOTOES; i++) begin
                drop[i] <= b_pulse[i] && pending[i] && !(accept && cmd_id == ID_W'(i));
                if (b_pulse[i])
                    pending[i] <= 1'b1;
                else if (accept && cmd_id == ID_W'(i))
                    pending[i] <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rr_any) begin
                        cmd_id    <= rr_id;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_OFFER;
                    end
                end

                // Offer is held untouched until taken: no re-arbitration.
                ST_OFFER: begin
                    if (accept) begin
                        cmd_valid  <= 1'b0;
                        last_grant <= cmd_id;
                        if (COOLDOWN == 16'd0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= COOLDOWN - 16'd1;
                            state <= ST_COOLDOWN;
                        end
                    end
                end

                ST_COOLDOWN: begin
                    if (cnt == 16'd0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                default: begin
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_botoes.sv
// Self-checking bench for arbitro_botoes: a directed vector table, hand-written
// corner sequences and a randomized run against a cycle-level reference model.
// Two instances: dut (COOLDOWN=4) and dut0 (COOLDOWN=0).
module tb_arbitro_botoes;
    import pkg_tamagotchi::*;

    localparam int N = 3;

    logic       clk;
    logic       rst;
    logic [2:0] b,  b0;
    logic       rdy, rdy0;
    logic       valid, valid0;
    logic [1:0] id, id0;
    logic [2:0] pend, pend0;
    logic [2:0] drp, drp0;
    logic       busy, busy0;

    int n_checks = 0;
    int n_err    = 0;
    int got[$];
    int got_cyc[$];

    arbitro_botoes #(.N_BOTOES(N), .ID_W(2), .COOLDOWN(16'd4)) dut (
        .clk(clk), .rst(rst), .b_pulse(b), .cmd_ready(rdy),
        .cmd_valid(valid), .cmd_id(id), .pending(pend), .busy(busy), .drop(drp)
    );

    arbitro_botoes #(.N_BOTOES(N), .ID_W(2), .COOLDOWN(16'd0)) dut0 (
        .clk(clk), .rst(rst), .b_pulse(b0), .cmd_ready(rdy0),
        .cmd_valid(valid0), .cmd_id(id0), .pending(pend0), .busy(busy0), .drop(drp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       off;      // a command is being offered
        int         off_id;
        int         last;
        int         wait_c;   // lockout cycles still to run
        logic [2:0] pend;
        logic [2:0] drop;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.off = 1'b0; m.off_id = 0; m.last = N - 1; m.wait_c = 0;
        m.pend = '0; m.drop = '0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic [2:0] bp, logic r, int cool);
        mdl_t n;
        bit   acc;
        bit   idle;
        n    = m;
        acc  = m.off && r;
        idle = !m.off && m.wait_c == 0;
        n.drop = '0;
        for (int i = 0; i < N; i++) begin
            if (bp[i]) begin
                if (m.pend[i] && !(acc && m.off_id == i)) n.drop[i] = 1'b1;
                n.pend[i] = 1'b1;
            end else if (acc && m.off_id == i) begin
                n.pend[i] = 1'b0;
            end
        end
        if (acc) begin
            n.off = 1'b0; n.last = m.off_id; n.wait_c = cool;
        end else if (m.wait_c != 0) begin
            n.wait_c = m.wait_c - 1;
        end else if (idle && m.pend != 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m.last + k) % N;
                if (m.pend[j]) begin
                    n.off = 1'b1; n.off_id = j;
                    break;
                end
            end
        end
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        b = '0; b0 = '0; rdy = 1'b0; rdy0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int c = 0;
        while (!valid && c < budget) begin
            tick();
            c++;
        end
        check(name, 32'(valid), 32'd1);
    endtask

    // Collect IDs accepted by dut with rdy held high.
    task automatic collect(input int n, input int budget);
        got.delete();
        for (int c = 0; c < budget && got.size() < n; c++) begin
            if (valid && rdy) got.push_back(int'(id));
            tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] b;
        logic       rdy;
        logic       v;
        logic [1:0] id;
        logic [2:0] p;
        logic [2:0] d;
        logic       bz;
    } vec_t;

    vec_t tbl[17];

    initial begin
        mdl_t m4, m0;
        logic [2:0] rb;
        logic       rr;

        rst = 1'b1; b = '0; b0 = '0; rdy = 1'b0; rdy0 = 1'b0;

        //          b       rdy   valid id     pend    drop    busy
        tbl[0]  = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{3'b010, 1'b1, 1'b0, 2'd0, 3'b010, 3'b000, 1'b0};
        tbl[2]  = '{3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 3'b000, 1'b1};
        tbl[3]  = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000, 3'b000, 1'b1};
        tbl[4]  = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000, 3'b000, 1'b1};
        tbl[5]  = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000, 3'b000, 1'b1};
        tbl[6]  = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000, 3'b000, 1'b1};
        tbl[7]  = '{3'b000, 1'b1, 1'b0, 2'd1, 3'b000, 3'b000, 1'b0};
        tbl[8]  = '{3'b111, 1'b1, 1'b0, 2'd1, 3'b111, 3'b000, 1'b0};
        tbl[9]  = '{3'b000, 1'b1, 1'b1, 2'd2, 3'b111, 3'b000, 1'b1};
        tbl[10] = '{3'b000, 1'b1, 1'b0, 2'd2, 3'b011, 3'b000, 1'b1};
        tbl[11] = '{3'b010, 1'b1, 1'b0, 2'd2, 3'b011, 3'b010, 1'b1};
        tbl[12] = '{3'b000, 1'b1, 1'b0, 2'd2, 3'b011, 3'b000, 1'b1};
        tbl[13] = '{3'b000, 1'b1, 1'b0, 2'd2, 3'b011, 3'b000, 1'b1};
        tbl[14] = '{3'b000, 1'b1, 1'b0, 2'd2, 3'b011, 3'b000, 1'b0};
        tbl[15] = '{3'b000, 1'b1, 1'b1, 2'd0, 3'b011, 3'b000, 1'b1};
        tbl[16] = '{3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 3'b000, 1'b1};

        // ---- reset state ----
        do_reset();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_id",    32'(id),    32'd0);
        check("rst_pend",  32'(pend),  32'd0);
        check("rst_drop",  32'(drp),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid0", 32'(valid0), 32'd0);

        // ---- table: single request, cooldown, rotation from last grant, drop ----
        for (int i = 0; i < 17; i++) begin
            b = tbl[i].b; rdy = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_id", i),    32'(id),    32'(tbl[i].id));
            check($sformatf("tbl%0d_pend", i),  32'(pend),  32'(tbl[i].p));
            check($sformatf("tbl%0d_drop", i),  32'(drp),   32'(tbl[i].d));
            check($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].bz));
        end
        b = '0;

        // ---- round-robin fairness from reset ----
        do_reset();
        rdy = 1'b1;
        b = 3'b111; tick(); b = '0;
        collect(3, 80);
        check("rr3_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("rr3_order%0d", k), 32'(k < got.size() ? got[k] : 99), 32'(k));
        b = '0;
        b[BTN_COMIDA] = 1'b1; b[BTN_LIMPAR] = 1'b1;
        tick(); b = '0;
        collect(2, 80);
        check("rr2_count", 32'(got.size()), 32'd2);
        check("rr2_first",  32'(got.size() > 0 ? got[0] : 99), 32'(BTN_COMIDA));
        check("rr2_second", 32'(got.size() > 1 ? got[1] : 99), 32'(BTN_LIMPAR));

        // ---- backpressure ----
        do_reset();
        rdy = 1'b0;
        b = 3'b010; tick(); b = '0;
        wait_valid(10, "bp_offer");
        for (int c = 0; c < 10; c++) begin
            b = (c == 3) ? 3'b001 : 3'b000;
            tick();
            check($sformatf("bp%0d_valid", c), 32'(valid), 32'd1);
            check($sformatf("bp%0d_id", c),    32'(id),    32'(BTN_BRINCAR));
            check($sformatf("bp%0d_busy", c),  32'(busy),  32'd1);
        end
        b = '0;
        check("bp_pend", 32'(pend), 32'b011);
        rdy = 1'b1; tick(); rdy = 1'b0;
        check("bp_acc_valid", 32'(valid), 32'd0);
        check("bp_acc_pend",  32'(pend),  32'b001);
        wait_valid(20, "bp_next");
        check("bp_next_id", 32'(id), 32'd0);

        // ---- drop and re-request in the accept cycle ----
        do_reset();
        rdy = 1'b0;
        b = 3'b100; tick();
        check("dr_pend", 32'(pend), 32'b100);
        check("dr_nodrop", 32'(drp), 32'b000);
        tick();
        check("dr_drop1", 32'(drp), 32'b100);
        b = '0; tick();
        check("dr_clear", 32'(drp), 32'b000);
        b = 3'b100; tick(); b = '0;
        check("dr_drop2", 32'(drp), 32'b100);
        wait_valid(10, "dr_offer");
        check("dr_offer_id", 32'(id), 32'd2);
        rdy = 1'b1; b = 3'b100; tick(); b = '0; rdy = 1'b0;
        check("dr_acc_valid", 32'(valid), 32'd0);
        check("dr_acc_pend",  32'(pend),  32'b100);
        check("dr_acc_drop",  32'(drp),   32'b000);
        check("dr_acc_busy",  32'(busy),  32'd1);
        wait_valid(20, "dr_reoffer");
        check("dr_reoffer_id", 32'(id), 32'd2);

        // ---- asynchronous reset while offering ----
        do_reset();
        rdy = 1'b0;
        b = 3'b010; tick(); b = 3'b100; tick(); b = '0;
        wait_valid(10, "ar_offer");
        #3 rst = 1'b1;
        #1;
        check("ar_valid", 32'(valid), 32'd0);
        check("ar_pend",  32'(pend),  32'd0);
        check("ar_busy",  32'(busy),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        b = 3'b011; tick(); b = '0;
        rdy = 1'b1;
        wait_valid(10, "ar_regrant");
        check("ar_first_id", 32'(id), 32'd0);
        rdy = 1'b0;

        // ---- COOLDOWN = 0 build: 2-cycle spacing ----
        do_reset();
        rdy0 = 1'b1;
        b0 = 3'b011; tick(); b0 = '0;
        got.delete(); got_cyc.delete();
        for (int c = 0; c < 40 && got.size() < 2; c++) begin
            if (valid0 && rdy0) begin
                got.push_back(int'(id0));
                got_cyc.push_back(c);
            end
            tick();
        end
        check("c0_count", 32'(got.size()), 32'd2);
        check("c0_first",  32'(got.size() > 0 ? got[0] : 99), 32'd0);
        check("c0_second", 32'(got.size() > 1 ? got[1] : 99), 32'd1);
        check("c0_spacing", 32'(got.size() > 1 ? got_cyc[1] - got_cyc[0] : 99), 32'd2);
        rdy0 = 1'b0;

        // ---- randomized run against the reference model ----
        do_reset();
        m4 = mdl_reset();
        m0 = mdl_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) rb[i] = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 9) < 6);
            b = rb; rdy = rr; b0 = rb; rdy0 = rr;
            tick();
            m4 = mdl_step(m4, rb, rr, 4);
            m0 = mdl_step(m0, rb, rr, 0);
            check("rnd_valid", 32'(valid), 32'(m4.off));
            check("rnd_id",    32'(id),    32'(m4.off_id));
            check("rnd_pend",  32'(pend),  32'(m4.pend));
            check("rnd_drop",  32'(drp),   32'(m4.drop));
            check("rnd_busy",  32'(busy),  32'(m4.off || m4.wait_c != 0));
            check("rnd0_valid", 32'(valid0), 32'(m0.off));
            check("rnd0_id",    32'(id0),    32'(m0.off_id));
            check("rnd0_pend",  32'(pend0),  32'(m0.pend));
            check("rnd0_drop",  32'(drp0),   32'(m0.drop));
            check("rnd0_busy",  32'(busy0),  32'(m0.off || m0.wait_c != 0));
        end
        b = '0; b0 = '0; rdy = 1'b0; rdy0 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
